ccip_req_rr_arb: RTL and testbench

- Shares one CCI-P request path (c0 reads, c1 writes) among N_CLIENTS independent AFU engines.
- Sits between the engines and the MPF "afu" side, next to the wires-to-MPF conversion in the top-level AFU.
- Arbitrates each channel round-robin and tags the high mdata bits with the client ID.
- Routes read and write responses back to the owning client and caps outstanding reads per client.

---
 rtl/ccip_rr_arb_pkg.sv | 27 ++
 rtl/ccip_rr_pick.sv | 30 +++
 rtl/ccip_req_rr_arb.sv | 189 ++++++++++++++++++
 tb/tb_ccip_req_rr_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_rr_arb_pkg.sv
// Shared types and FIU mdata tag/strip helpers for the CCI-P round-robin request arbiter.
// The client ID occupies the top ID_BITS of the FIU-side mdata field.
package ccip_rr_arb_pkg;

  localparam int META_MAX_W = 64;

  typedef logic [2:0]            t_client_id;
  typedef logic [15:0]           t_rd_count;
  typedef logic [META_MAX_W-1:0] t_meta;

  function automatic t_meta tag_mdata(t_client_id id, t_meta cl_mdata, int mdata_w, int id_bits);
    t_meta low_mask;
    low_mask = (t_meta'(1) << (mdata_w - id_bits)) - t_meta'(1);
    return (t_meta'(id) << (mdata_w - id_bits)) | (cl_mdata & low_mask);
  endfunction

  function automatic t_client_id mdata_id(t_meta mdata, int mdata_w, int id_bits);
    t_meta id_mask;
    id_mask = (t_meta'(1) << id_bits) - t_meta'(1);
    return t_client_id'((mdata >> (mdata_w - id_bits)) & id_mask);
  endfunction

  function automatic t_meta strip_mdata(t_meta mdata, int mdata_w, int id_bits);
    return mdata & ((t_meta'(1) << (mdata_w - id_bits)) - t_meta'(1));
  endfunction

endpackage

// File: rtl/ccip_rr_pick.sv
// Round-robin picker: first eligible index searching upward from ptr+1 (mod N).
module ccip_rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             found,
  output logic [PTR_W-1:0] ptr_nxt
);

  int idx;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    ptr_nxt = ptr;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ccip_req_rr_arb.sv
// Shares one CCI-P c0/c1 request path among N_CLIENTS engines, tags mdata with the
// client ID, routes responses back by that ID and caps outstanding reads per client.
module ccip_req_rr_arb
  import ccip_rr_arb_pkg::*;
#(
  parameter int N_CLIENTS  = 4,
  parameter int ID_BITS    = 2,
  parameter int MAX_RD_OUT = 64,
  parameter int ADDR_W     = 42,
  parameter int MDATA_W    = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_CLIENTS-1:0]                   cl_c0_valid,
  input  logic [N_CLIENTS*ADDR_W-1:0]            cl_c0_addr,
  input  logic [N_CLIENTS*(MDATA_W-ID_BITS)-1:0] cl_c0_mdata,
  output logic [N_CLIENTS-1:0]                   cl_c0_grant,
  input  logic [N_CLIENTS-1:0]                   cl_c1_valid,
  input  logic [N_CLIENTS*ADDR_W-1:0]            cl_c1_addr,
  input  logic [N_CLIENTS*(MDATA_W-ID_BITS)-1:0] cl_c1_mdata,
  input  logic [N_CLIENTS*512-1:0]               cl_c1_data,
  output logic [N_CLIENTS-1:0]                   cl_c1_grant,
  output logic                                   fiu_c0_valid,
  output logic [ADDR_W-1:0]                      fiu_c0_addr,
  output logic [MDATA_W-1:0]                     fiu_c0_mdata,
  input  logic                                   fiu_c0_almfull,
  output logic                                   fiu_c1_valid,
  output logic [ADDR_W-1:0]                      fiu_c1_addr,
  output logic [MDATA_W-1:0]                     fiu_c1_mdata,
  output logic [511:0]                           fiu_c1_data,
  input  logic                                   fiu_c1_almfull,
  input  logic                                   fiu_c0rx_valid,
  input  logic [MDATA_W-1:0]                     fiu_c0rx_mdata,
  input  logic [511:0]                           fiu_c0rx_data,
  input  logic                                   fiu_c1rx_valid,
  input  logic [MDATA_W-1:0]                     fiu_c1rx_mdata,
  output logic [N_CLIENTS-1:0]                   cl_c0rx_valid,
  output logic [MDATA_W-ID_BITS-1:0]             cl_c0rx_mdata,
  output logic [511:0]                           cl_c0rx_data,
  output logic [N_CLIENTS-1:0]                   cl_c1rx_valid,
  output logic [MDATA_W-ID_BITS-1:0]             cl_c1rx_mdata,
  output logic                                   err_unrouted
);

  localparam int CL_MW = MDATA_W - ID_BITS;
  localparam int PTR_W = $clog2(N_CLIENTS);

  logic [PTR_W-1:0]     ptr0, ptr1, ptr0_nxt, ptr1_nxt;
  logic                 found0, found1;
  logic [N_CLIENTS-1:0] elig0, elig1;
  t_rd_count            rd_out [N_CLIENTS];

  logic [ADDR_W-1:0]    sel0_addr, sel1_addr;
  logic [CL_MW-1:0]     sel0_mdata, sel1_mdata;
  logic [511:0]         sel1_data;

  t_client_id           rx0_id, rx1_id;
  logic                 rx0_ok, rx1_ok;
  logic [N_CLIENTS-1:0] rx0_hit, rx1_hit;
  logic                 underflow;

  always_comb begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      elig0[i] = cl_c0_valid[i] && !fiu_c0_almfull && (rd_out[i] < t_rd_count'(MAX_RD_OUT));
    end
    elig1 = cl_c1_valid & {N_CLIENTS{~fiu_c1_almfull}};
  end

  ccip_rr_pick #(.N(N_CLIENTS), .PTR_W(PTR_W)) u_pick_c0 (
    .eligible (elig0),
    .ptr      (ptr0),
    .grant    (cl_c0_grant),
    .found    (found0),
    .ptr_nxt  (ptr0_nxt)
  );

  ccip_rr_pick #(.N(N_CLIENTS), .PTR_W(PTR_W)) u_pick_c1 (
    .eligible (elig1),
    .ptr      (ptr1),
    .grant    (cl_c1_grant),
    .found    (found1),
    .ptr_nxt  (ptr1_nxt)
  );

  always_comb begin
    sel0_addr  = '0;
    sel0_mdata = '0;
    sel1_addr  = '0;
    sel1_mdata = '0;
    sel1_data  = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (cl_c0_grant[i]) begin
        sel0_addr  = cl_c0_addr[i*ADDR_W +: ADDR_W];
        sel0_mdata = cl_c0_mdata[i*CL_MW +: CL_MW];
      end
      if (cl_c1_grant[i]) begin
        sel1_addr  = cl_c1_addr[i*ADDR_W +: ADDR_W];
        sel1_mdata = cl_c1_mdata[i*CL_MW +: CL_MW];
        sel1_data  = cl_c1_data[i*512 +: 512];
      end
    end
  end

  // Response decode: IDs at or above N_CLIENTS have no owner and are dropped.
  always_comb begin
    rx0_id    = mdata_id(t_meta'(fiu_c0rx_mdata), MDATA_W, ID_BITS);
    rx1_id    = mdata_id(t_meta'(fiu_c1rx_mdata), MDATA_W, ID_BITS);
    rx0_ok    = int'(rx0_id) < N_CLIENTS;
    rx1_ok    = int'(rx1_id) < N_CLIENTS;
    underflow = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      rx0_hit[i] = fiu_c0rx_valid && rx0_ok && (int'(rx0_id) == i);
      rx1_hit[i] = fiu_c1rx_valid && rx1_ok && (int'(rx1_id) == i);
      if (rx0_hit[i] && (rd_out[i] == '0)) underflow = 1'b1;
    end
  end

  // ---- stage p0: registered FIU requests and routed responses ----
  logic                 c0_vld_p0, c1_vld_p0;
  logic [ADDR_W-1:0]    c0_addr_p0, c1_addr_p0;
  logic [MDATA_W-1:0]   c0_mdata_p0, c1_mdata_p0;
  logic [511:0]         c1_data_p0;
  logic [N_CLIENTS-1:0] c0rx_vld_p0, c1rx_vld_p0;
  logic [CL_MW-1:0]     c0rx_mdata_p0, c1rx_mdata_p0;
  logic [511:0]         c0rx_data_p0;
  logic                 err_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      c0_vld_p0   <= 1'b0;
      c1_vld_p0   <= 1'b0;
      c0rx_vld_p0 <= '0;
      c1rx_vld_p0 <= '0;
      err_p0      <= 1'b0;
      ptr0        <= PTR_W'(N_CLIENTS - 1);
      ptr1        <= PTR_W'(N_CLIENTS - 1);
      for (int i = 0; i < N_CLIENTS; i++) rd_out[i] <= '0;
    end else begin
      c0_vld_p0   <= found0;
      c1_vld_p0   <= found1;
      c0rx_vld_p0 <= rx0_hit;
      c1rx_vld_p0 <= rx1_hit;
      if (found0) ptr0 <= ptr0_nxt;
      if (found1) ptr1 <= ptr1_nxt;
      if ((fiu_c0rx_valid && !rx0_ok) || (fiu_c1rx_valid && !rx1_ok) || underflow)
        err_p0 <= 1'b1;
      // A grant and a response for the same client cancel out.
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (cl_c0_grant[i] && !rx0_hit[i])
          rd_out[i] <= rd_out[i] + t_rd_count'(1);
        else if (rx0_hit[i] && !cl_c0_grant[i] && (rd_out[i] != '0))
          rd_out[i] <= rd_out[i] - t_rd_count'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (found0) begin
      c0_addr_p0  <= sel0_addr;
      c0_mdata_p0 <= MDATA_W'(tag_mdata(t_client_id'(ptr0_nxt), t_meta'(sel0_mdata), MDATA_W, ID_BITS));
    end
    if (found1) begin
      c1_addr_p0  <= sel1_addr;
      c1_mdata_p0 <= MDATA_W'(tag_mdata(t_client_id'(ptr1_nxt), t_meta'(sel1_mdata), MDATA_W, ID_BITS));
      c1_data_p0  <= sel1_data;
    end
    if (fiu_c0rx_valid) begin
      c0rx_mdata_p0 <= CL_MW'(strip_mdata(t_meta'(fiu_c0rx_mdata), MDATA_W, ID_BITS));
      c0rx_data_p0  <= fiu_c0rx_data;
    end
    if (fiu_c1rx_valid)
      c1rx_mdata_p0 <= CL_MW'(strip_mdata(t_meta'(fiu_c1rx_mdata), MDATA_W, ID_BITS));
  end

  assign fiu_c0_valid  = c0_vld_p0;
  assign fiu_c0_addr   = c0_addr_p0;
  assign fiu_c0_mdata  = c0_mdata_p0;
  assign fiu_c1_valid  = c1_vld_p0;
  assign fiu_c1_addr   = c1_addr_p0;
  assign fiu_c1_mdata  = c1_mdata_p0;
  assign fiu_c1_data   = c1_data_p0;
  assign cl_c0rx_valid = c0rx_vld_p0;
  assign cl_c0rx_mdata = c0rx_mdata_p0;
  assign cl_c0rx_data  = c0rx_data_p0;
  assign cl_c1rx_valid = c1rx_vld_p0;
  assign cl_c1rx_mdata = c1rx_mdata_p0;
  assign err_unrouted  = err_p0;

endmodule

// File: tb/tb_ccip_req_rr_arb.sv
// Bench for ccip_req_rr_arb: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural arbitration/routing model.
module tb_ccip_req_rr_arb;

  localparam int N    = 3;
  localparam int IDB  = 2;
  localparam int MAXO = 4;
  localparam int AW   = 42;
  localparam int MW   = 16;
  localparam int CW   = MW - IDB;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]    c0_valid, c1_valid, g0, g1;
  logic [N*AW-1:0] c0_addr, c1_addr;
  logic [N*CW-1:0] c0_mdata, c1_mdata;
  logic [N*512-1:0] c1_data;
  logic almfull0, almfull1, rx0_valid, rx1_valid;
  logic [MW-1:0]   rx0_mdata, rx1_mdata;
  logic [511:0]    rx0_data;
  logic            f0_valid, f1_valid, err;
  logic [AW-1:0]   f0_addr, f1_addr;
  logic [MW-1:0]   f0_mdata, f1_mdata;
  logic [511:0]    f1_data, clrx0_data;
  logic [N-1:0]    clrx0_valid, clrx1_valid;
  logic [CW-1:0]   clrx0_mdata, clrx1_mdata;

  always #5 clk = ~clk;

  ccip_req_rr_arb #(.N_CLIENTS(N), .ID_BITS(IDB), .MAX_RD_OUT(MAXO), .ADDR_W(AW), .MDATA_W(MW)) dut (
    .clk(clk), .reset(reset),
    .cl_c0_valid(c0_valid), .cl_c0_addr(c0_addr), .cl_c0_mdata(c0_mdata), .cl_c0_grant(g0),
    .cl_c1_valid(c1_valid), .cl_c1_addr(c1_addr), .cl_c1_mdata(c1_mdata), .cl_c1_data(c1_data),
    .cl_c1_grant(g1),
    .fiu_c0_valid(f0_valid), .fiu_c0_addr(f0_addr), .fiu_c0_mdata(f0_mdata), .fiu_c0_almfull(almfull0),
    .fiu_c1_valid(f1_valid), .fiu_c1_addr(f1_addr), .fiu_c1_mdata(f1_mdata), .fiu_c1_data(f1_data),
    .fiu_c1_almfull(almfull1),
    .fiu_c0rx_valid(rx0_valid), .fiu_c0rx_mdata(rx0_mdata), .fiu_c0rx_data(rx0_data),
    .fiu_c1rx_valid(rx1_valid), .fiu_c1rx_mdata(rx1_mdata),
    .cl_c0rx_valid(clrx0_valid), .cl_c0rx_mdata(clrx0_mdata), .cl_c0rx_data(clrx0_data),
    .cl_c1rx_valid(clrx1_valid), .cl_c1rx_mdata(clrx1_mdata),
    .err_unrouted(err)
  );

  int checks = 0;
  int failures = 0;
  bit checking = 0;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model state
  int           m_ptr0, m_ptr1;
  int           m_rd [N];
  logic         e_f0v, e_f1v, e_err;
  logic [AW-1:0] e_f0a, e_f1a;
  logic [MW-1:0] e_f0m, e_f1m;
  logic [511:0] e_f1d, e_r0d;
  logic [N-1:0] e_r0v, e_r1v, mg0, mg1;
  logic [CW-1:0] e_r0m, e_r1m;
  logic [MW-1:0] pend [$];

  function automatic int rr_pick(logic [N-1:0] elig, int ptr);
    for (int k = 1; k <= N; k++)
      if (elig[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    e_f0v = 0; e_f1v = 0; e_r0v = '0; e_r1v = '0; e_err = 0;
    m_ptr0 = N - 1; m_ptr1 = N - 1;
    for (int i = 0; i < N; i++) m_rd[i] = 0;
    pend.delete();
    mg0 = '0; mg1 = '0;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      logic [N-1:0] el0, el1;
      int p0, p1, id0, id1;
      chk("fiu_c0_valid", f0_valid, e_f0v);
      if (e_f0v) begin
        chk("fiu_c0_addr", f0_addr, e_f0a);
        chk("fiu_c0_mdata", f0_mdata, e_f0m);
      end
      chk("fiu_c1_valid", f1_valid, e_f1v);
      if (e_f1v) begin
        chk("fiu_c1_addr", f1_addr, e_f1a);
        chk("fiu_c1_mdata", f1_mdata, e_f1m);
        chk("fiu_c1_data", f1_data, e_f1d);
      end
      chk("cl_c0rx_valid", clrx0_valid, e_r0v);
      if (e_r0v != 0) begin
        chk("cl_c0rx_mdata", clrx0_mdata, e_r0m);
        chk("cl_c0rx_data", clrx0_data, e_r0d);
      end
      chk("cl_c1rx_valid", clrx1_valid, e_r1v);
      if (e_r1v != 0) chk("cl_c1rx_mdata", clrx1_mdata, e_r1m);
      chk("err_unrouted", err, e_err);

      if (reset) begin
        model_reset();
      end else begin
        for (int i = 0; i < N; i++) begin
          el0[i] = c0_valid[i] && !almfull0 && (m_rd[i] < MAXO);
          el1[i] = c1_valid[i] && !almfull1;
        end
        p0 = rr_pick(el0, m_ptr0);
        p1 = rr_pick(el1, m_ptr1);
        mg0 = (p0 >= 0) ? N'(1) << p0 : '0;
        mg1 = (p1 >= 0) ? N'(1) << p1 : '0;
        chk("cl_c0_grant", g0, mg0);
        chk("cl_c1_grant", g1, mg1);

        e_f0v = (p0 >= 0);
        if (p0 >= 0) begin
          e_f0a = c0_addr[p0*AW +: AW];
          e_f0m = MW'(p0 << CW) | MW'(c0_mdata[p0*CW +: CW]);
          m_ptr0 = p0;
          pend.push_back(e_f0m);
        end
        e_f1v = (p1 >= 0);
        if (p1 >= 0) begin
          e_f1a = c1_addr[p1*AW +: AW];
          e_f1m = MW'(p1 << CW) | MW'(c1_mdata[p1*CW +: CW]);
          e_f1d = c1_data[p1*512 +: 512];
          m_ptr1 = p1;
        end

        e_r0v = '0;
        id0 = -1;
        if (rx0_valid) begin
          id0 = int'(rx0_mdata >> CW);
          if (id0 >= N) begin
            e_err = 1;
            id0 = -1;
          end else begin
            e_r0v = N'(1) << id0;
            e_r0m = rx0_mdata[CW-1:0];
            e_r0d = rx0_data;
            if (m_rd[id0] == 0) e_err = 1;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (p0 == i && id0 != i) m_rd[i]++;
          else if (id0 == i && p0 != i && m_rd[i] > 0) m_rd[i]--;
        end

        e_r1v = '0;
        if (rx1_valid) begin
          id1 = int'(rx1_mdata >> CW);
          if (id1 >= N) e_err = 1;
          else begin
            e_r1v = N'(1) << id1;
            e_r1m = rx1_mdata[CW-1:0];
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_client(int i, bit ch1);
    if (!ch1) begin
      c0_valid[i] = $urandom_range(0, 1) == 1;
      c0_addr[i*AW +: AW] = AW'({$urandom, $urandom});
      c0_mdata[i*CW +: CW] = CW'($urandom);
    end else begin
      c1_valid[i] = $urandom_range(0, 1) == 1;
      c1_addr[i*AW +: AW] = AW'({$urandom, $urandom});
      c1_mdata[i*CW +: CW] = CW'($urandom);
      for (int w = 0; w < 16; w++) c1_data[i*512 + w*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    logic [511:0] pat;
    int idx;
    reset = 1; c0_valid = '0; c1_valid = '0; almfull0 = 0; almfull1 = 0;
    rx0_valid = 0; rx1_valid = 0; rx0_mdata = '0; rx1_mdata = '0; rx0_data = '0;
    c0_addr = '0; c1_addr = '0; c0_mdata = '0; c1_mdata = '0; c1_data = '0;
    model_reset();
    repeat (2) cyc();
    checking = 1;
    #2;
    chk("reset_f0_valid", f0_valid, 0);
    chk("reset_f1_valid", f1_valid, 0);
    chk("reset_rx_valid", {clrx0_valid, clrx1_valid}, 0);
    chk("reset_err", err, 0);
    reset = 0;
    cyc();

    // Round robin over all clients
    for (int i = 0; i < N; i++) begin
      c0_addr[i*AW +: AW] = AW'(42'h1000 + i);
      c0_mdata[i*CW +: CW] = CW'(14'h100 + i);
    end
    c0_valid = '1;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("rr_grant", g0, N'(1) << (k % N));
      if (k > 0) chk("rr_tag", f0_mdata, MW'(((k - 1) % N) << CW) | MW'(14'h100 + (k - 1) % N));
      cyc();
    end

    // Reset mid-burst abandons everything
    reset = 1; c0_valid = '0;
    cyc();
    #2;
    chk("midreset_f0_valid", f0_valid, 0);
    chk("midreset_err", err, 0);
    reset = 0;
    cyc();

    // c1 blocked by almost-full
    almfull1 = 1;
    c1_valid = 3'b100;
    c1_addr[2*AW +: AW] = 42'h2222;
    c1_mdata[2*CW +: CW] = 14'h0222;
    pat = {16{32'hA5A5_0002}};
    c1_data[2*512 +: 512] = pat;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("almfull_no_grant", g1, 0);
      chk("almfull_no_valid", f1_valid, 0);
      cyc();
    end
    almfull1 = 0;
    #2;
    chk("almfull_release_grant", g1, 3'b100);
    cyc();
    c1_valid = '0;
    #2;
    chk("almfull_f1_valid", f1_valid, 1);
    chk("almfull_f1_mdata", f1_mdata, 16'h8222);
    chk("almfull_f1_data", f1_data, pat);
    cyc();

    // Outstanding-read cap for client 1
    c0_valid = 3'b010;
    for (int k = 0; k < MAXO; k++) begin
      #2;
      chk("cap_grant", g0, 3'b010);
      cyc();
    end
    #2;
    chk("cap_block", g0, 0);
    cyc();
    rx0_valid = 1; rx0_mdata = 16'h4101; rx0_data = {16{32'h1111_2222}};
    #2;
    chk("cap_block_during_rx", g0, 0);
    cyc();
    rx0_valid = 0;
    #2;
    chk("cap_release", g0, 3'b010);
    chk("cap_rx_strobe", clrx0_valid, 3'b010);
    cyc();
    c0_valid = '0;

    // Response routing and ID strip; client 2 has nothing outstanding
    pat = {8{64'hDEAD_BEEF_0123_4567}};
    rx0_valid = 1; rx0_mdata = 16'h8ABC; rx0_data = pat;
    cyc();
    rx0_valid = 0;
    #2;
    chk("route_strobe", clrx0_valid, 3'b100);
    chk("route_mdata", clrx0_mdata, 14'h0ABC);
    chk("route_data", clrx0_data, pat);
    chk("route_underflow_err", err, 1);
    cyc();

    // Simultaneous grant and response at rd_out=3
    reset = 1;
    cyc();
    reset = 0;
    c0_valid = 3'b001;
    repeat (3) cyc();
    rx0_valid = 1; rx0_mdata = 16'h0001;
    #2;
    chk("same_cycle_grant", g0, 3'b001);
    cyc();
    rx0_valid = 0;
    #2;
    chk("after_same_grant", g0, 3'b001);
    cyc();
    #2;
    chk("after_same_cap", g0, 0);
    c0_valid = '0;
    cyc();

    // Unrouted ID is dropped and sticky
    reset = 1;
    cyc();
    reset = 0;
    rx1_valid = 1; rx1_mdata = 16'hC123;
    cyc();
    rx1_valid = 0;
    #2;
    chk("unrouted_no_strobe", clrx1_valid, 0);
    chk("unrouted_err", err, 1);
    cyc();
    repeat (3) begin
      #2;
      chk("unrouted_err_hold", err, 1);
      cyc();
    end
    c0_valid = '1; c1_valid = '1;
    repeat (2) cyc();
    reset = 1;
    cyc();
    #2;
    chk("burst_reset_f0", f0_valid, 0);
    chk("burst_reset_f1", f1_valid, 0);
    chk("burst_reset_err", err, 0);
    reset = 0; c0_valid = '0; c1_valid = '0;
    rx0_valid = 1; rx0_mdata = 16'h4055;
    cyc();
    rx0_valid = 0;
    #2;
    chk("post_reset_route", clrx0_valid, 3'b010);
    chk("post_reset_guard_err", err, 1);
    cyc();

    // Random traffic against the model
    reset = 1;
    cyc();
    reset = 0;
    for (int n = 0; n < 3000; n++) begin
      almfull0 = $urandom_range(0, 9) < 2;
      almfull1 = $urandom_range(0, 9) < 2;
      for (int i = 0; i < N; i++) begin
        if (!(c0_valid[i] && !mg0[i])) rand_client(i, 0);
        if (!(c1_valid[i] && !mg1[i])) rand_client(i, 1);
      end
      if (pend.size() > 0 && $urandom_range(0, 99) < 40) begin
        idx = $urandom_range(0, pend.size() - 1);
        rx0_mdata = pend[idx];
        pend.delete(idx);
        rx0_valid = 1;
        for (int w = 0; w < 16; w++) rx0_data[w*32 +: 32] = $urandom;
      end else begin
        rx0_valid = 0;
      end
      rx1_valid = $urandom_range(0, 99) < 30;
      rx1_mdata = MW'($urandom_range(0, N - 1) << CW) | MW'(CW'($urandom));
      reset = $urandom_range(0, 499) == 0;
      cyc();
    end
    reset = 0; c0_valid = '0; c1_valid = '0; rx0_valid = 0; rx1_valid = 0;
    repeat (3) cyc();
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
